abr_ram_stream_rd: RTL
======================

# abr_ram_stream_rd

Read sequencer for the abr_1r1w_ram read port. A single command fetches a contiguous, wrapping address range and delivers the words in order as a valid/ready stream. Reads are throttled by a credit scheme against a fixed 4-entry output buffer, so downstream backpressure never drops or duplicates a word. The block sits between an abr_1r1w_ram instance and a consumer such as an NTT/sampler datapath that must drain a buffered polynomial.

## Interface
Parameters:
- DEPTH, 64: word count of the attached RAM.
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, $clog2(DEPTH): RAM address width.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset, asynchronous and active-high.
- start_i  in  1  command strobe; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first address; sampled with start_i.
- len_i  in  ADDR_WIDTH+1  word count, 0..DEPTH; sampled with start_i.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle completion pulse.
- ram_re_o  out  1  RAM read enable; connects to re_i.
- ram_raddr_o  out  ADDR_WIDTH  RAM read address; connects to raddr_i.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; valid the cycle after ram_re_o.
- valid_o  out  1  stream data valid.
- data_o  out  DATA_WIDTH  stream data; the buffer head.
- ready_i  in  1  consumer accept.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start_i=1 and len_i>0: latch base and len, go to ISSUE.
  - start_i=1 and len_i==0: stay in IDLE, pulse done_o the next cycle, issue no reads.
- ISSUE:
  - ram_re_o = (occ + inflight < 4) and (remaining issues > 0).
  - Each issue advances the address register modulo DEPTH (DEPTH-1 wraps to 0) and decrements the issue count.
  - After the last issue, go to DRAIN.
- DRAIN: when the final word is accepted (valid_o && ready_i with the accept count reaching len), go to IDLE and pulse done_o.
- Read pipeline:
  - inflight (0..2) counts reads issued but not yet written into the buffer.
  - The read issued in cycle t returns on ram_rdata_i in cycle t+1. A 1-cycle delayed copy of ram_re_o writes ram_rdata_i into the buffer at the end of t+1.
  - The buffer is a 4-entry circular FIFO with 2-bit pointers and an occupancy count 0..4.
  - A buffer push and a pop in the same cycle leave occupancy unchanged.
  - The credit rule guarantees a push never finds the buffer full.
- Output stream:
  - valid_o = (occ != 0); data_o = buffer head.
  - Once valid_o is high, data_o holds until the handshake.
- start_i is ignored while busy_o=1.
- busy_o = (state != IDLE).
- ram_re_o is never high in IDLE.

## Timing
- Reset values: busy_o=0, done_o=0, ram_re_o=0, ram_raddr_o=0, valid_o=0, data_o=0; FSM=IDLE, occ=0, inflight=0.
- Reset asserted mid-command aborts immediately: buffer contents are discarded and no done_o is issued.
- start_i sampled at edge 0:
  - first ram_re_o in cycle 1;
  - first valid_o in cycle 3 (start-to-first-data latency is 3 cycles).
- Throughput with ready_i held high: 1 word/cycle, with continuous ram_re_o from cycle 1 to cycle len.
- done_o is high in the cycle after the last handshake edge; busy_o is low in that same cycle.
- A new start_i is accepted in the same cycle as done_o.
- With ready_i low, at most 4 reads are outstanding, after which ram_re_o stays low. Issue resumes the cycle after a pop frees a credit.
- len==DEPTH reads every location exactly once, starting at base and wrapping.

## Test plan
- base=5, len=4, ready_i=1, RAM preloaded mem[a]=a+100: reads 5,6,7,8 in cycles 1-4; data 105..108 in cycles 3-6; done_o in cycle 7.
- base=62, len=4, DEPTH=64: ram_raddr_o sequence is 62,63,0,1; the stream matches mem order; no extra reads.
- len=8 with ready_i low for cycles 2-10: exactly 4 reads are issued, then ram_re_o=0 until the first pop. All 8 words are delivered in order with no loss or duplicate, and data_o is stable while stalled.
- start_i with len=0: done_o pulses the next cycle, ram_re_o never rises, valid_o stays 0.
- start_i pulsed again mid-command, then len=DEPTH: the mid-command start is ignored; the full-depth command reads all 64 addresses once, and done_o pulses exactly once.
- rst_i asserted in cycle 4 of a len=16 command: all outputs return to reset values asynchronously. A subsequent command at base=0, len=2 completes normally.

Source files
------------

// File: rtl/abr_ram_stream_rd_if.sv
// Command, RAM read-port and output-stream signals of the RAM stream reader.
// master: the sequencer itself. slave: the surrounding environment.
interface abr_ram_stream_rd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  ram_re_o;
  logic [ADDR_WIDTH-1:0] ram_raddr_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  ready_i;

  modport master (
    input  start_i, base_addr_i, len_i, ram_rdata_i, ready_i,
    output busy_o, done_o, ram_re_o, ram_raddr_o, valid_o, data_o
  );

  modport slave (
    output start_i, base_addr_i, len_i, ram_rdata_i, ready_i,
    input  busy_o, done_o, ram_re_o, ram_raddr_o, valid_o, data_o
  );
endinterface

// File: rtl/abr_ram_stream_rd.sv
// Read sequencer for a 1R1W RAM: one command streams a contiguous, wrapping
// address range out as valid/ready words. Reads are credit-limited against a
// 4-entry output buffer so backpressure never drops or duplicates a word.
module abr_ram_stream_rd #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  abr_ram_stream_rd_if.master bus
);
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [CNT_W-1:0]      acc_cnt_q;
  logic [2:0]            occ_q;
  logic [1:0]            inflight_q;
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic                  vld_p1;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] buf_mem [4];

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic [3:0]            credit_used;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Credit check, handshake decode and wrapping next address
  always_comb begin
    credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
    issue       = (state_q == ISSUE) && (credit_used < 4'd4) && (issue_cnt_q != '0);
    valid       = (occ_q != 3'd0);
    push        = vld_p1;
    pop         = valid && bus.ready_i;
    addr_next   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
  end

  // Command FSM, issue/accept counters, credit and buffer bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      occ_q       <= 3'd0;
      inflight_q  <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      vld_p1      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // stage p0 -> p1: read issued this cycle lands in the buffer next cycle
      vld_p1 <= issue;

      if (issue && !push)      inflight_q <= inflight_q + 2'd1;
      else if (!issue && push) inflight_q <= inflight_q - 2'd1;

      if (push && !pop)      occ_q <= occ_q + 3'd1;
      else if (!push && pop) occ_q <= occ_q - 3'd1;

      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;

      if (issue) begin
        addr_q      <= addr_next;
        issue_cnt_q <= issue_cnt_q - CNT_W'(1);
      end
      if (pop) acc_cnt_q <= acc_cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i != '0) begin
              addr_q      <= bus.base_addr_i;
              len_q       <= bus.len_i;
              issue_cnt_q <= bus.len_i;
              acc_cnt_q   <= '0;
              state_q     <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue && (issue_cnt_q == CNT_W'(1))) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && (acc_cnt_q + CNT_W'(1) == len_q)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer storage: data path only, contents never need clearing
  always_ff @(posedge clk_i) begin
    // stage p1 -> buffer: returned RAM word written at the tail
    if (push) buf_mem[wr_ptr_q] <= bus.ram_rdata_i;
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;
  assign bus.ram_re_o    = issue;
  assign bus.ram_raddr_o = addr_q;
  assign bus.valid_o     = valid;
  assign bus.data_o      = valid ? buf_mem[rd_ptr_q] : '0;
endmodule
